// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
//   state_t         refill controller states
//   ofs_bits()      byte-offset width (word select + byte-in-word bits)
//   idx_bits()      line-index width
//   DEF_*           default geometry and the field widths derived from it
package icache_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    function automatic int ofs_bits(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    localparam int DEF_LINES      = 8;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_OFS_W      = ofs_bits(DEF_LINE_WORDS);
    localparam int DEF_IDX_W      = idx_bits(DEF_LINES);
    localparam int DEF_TAG_W      = DEF_ADDR_W - DEF_OFS_W - DEF_IDX_W;

endpackage

// File: rtl/icache_line_store.sv
// Tag and data arrays of the instruction cache. Neither array is reset; the
// valid bits in the top level decide whether their contents mean anything.
//   clk          clock
//   wr_en        write a whole line (tag + all words) at wr_idx
//   wr_idx       line index to write
//   wr_tag       tag to store
//   wr_line      line data, word 0 in bits [31:0]
//   rd_idx       line index to read (combinational)
//   rd_word_sel  word within the line to read
//   rd_tag       stored tag at rd_idx
//   rd_word      selected 32-bit word at rd_idx
module icache_line_store #(
    parameter int LINES      = 8,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 3,
    parameter int TAG_W      = 25,
    parameter int WSEL_W     = 2
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [TAG_W-1:0]          wr_tag,
    input  logic [32*LINE_WORDS-1:0]  wr_line,
    input  logic [IDX_W-1:0]          rd_idx,
    input  logic [WSEL_W-1:0]         rd_word_sel,
    output logic [TAG_W-1:0]          rd_tag,
    output logic [31:0]               rd_word
);

    logic [TAG_W-1:0]         tag_q  [LINES];
    logic [TAG_W-1:0]         tag_d  [LINES];
    logic [32*LINE_WORDS-1:0] data_q [LINES];
    logic [32*LINE_WORDS-1:0] data_d [LINES];

    always_comb begin
        tag_d  = tag_q;
        data_d = data_q;
        if (wr_en) begin
            tag_d[wr_idx]  = wr_tag;
            data_d[wr_idx] = wr_line;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_tag  = tag_q[rd_idx];
    assign rd_word = data_q[rd_idx][{rd_word_sel, 5'd0} +: 32];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache in front of a line-wide memory.
// Hits return the instruction combinationally; a miss stalls the core, fetches
// one whole line over a req/ready handshake and then replays as a hit.
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   proc_read    fetch request valid
//   proc_addr    byte fetch address, bits [1:0] ignored
//   proc_rdata   instruction, valid when proc_read & !proc_stall
//   proc_stall   core must hold its PC
//   inv_all      invalidate every line
//   mem_read     registered line-refill request
//   mem_addr     registered line-aligned refill address
//   mem_rdata    refill line, word 0 in bits [31:0]
//   mem_ready    one-cycle pulse completing the refill
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | lookups served; a miss registers the refill request
// S_FETCH | mem_read held with stable mem_addr until mem_ready
module icache_direct_mapped
    import icache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      proc_read,
    input  logic [ADDR_W-1:0]         proc_addr,
    output logic [31:0]               proc_rdata,
    output logic                      proc_stall,
    input  logic                      inv_all,
    output logic                      mem_read,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [32*LINE_WORDS-1:0]  mem_rdata,
    input  logic                      mem_ready
);

    localparam int OFS    = ofs_bits(LINE_WORDS);
    localparam int IDX    = idx_bits(LINES);
    localparam int TAG    = ADDR_W - OFS - IDX;
    localparam int WSEL_W = OFS - 2;

    state_t              state_q, state_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic                mem_read_q, mem_read_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    logic [IDX-1:0]      req_idx, fill_idx;
    logic [TAG-1:0]      req_tag, fill_tag, stored_tag;
    logic [WSEL_W-1:0]   req_word;
    logic                hit;
    logic                fill_we;
    logic                unused_byte_bits;

    assign req_word = proc_addr[OFS-1:2];
    assign req_idx  = proc_addr[OFS+IDX-1:OFS];
    assign req_tag  = proc_addr[ADDR_W-1:OFS+IDX];
    assign fill_idx = mem_addr_q[OFS+IDX-1:OFS];
    assign fill_tag = mem_addr_q[ADDR_W-1:OFS+IDX];

    assign unused_byte_bits = ^proc_addr[1:0];

    icache_line_store #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX),
        .TAG_W      (TAG),
        .WSEL_W     (WSEL_W)
    ) u_store (
        .clk         (clk),
        .wr_en       (fill_we),
        .wr_idx      (fill_idx),
        .wr_tag      (fill_tag),
        .wr_line     (mem_rdata),
        .rd_idx      (req_idx),
        .rd_word_sel (req_word),
        .rd_tag      (stored_tag),
        .rd_word     (proc_rdata)
    );

    // A flush in the same cycle forces the lookup to miss even though the
    // valid bit is only cleared at the coming edge.
    assign hit        = proc_read & ~inv_all & valid_q[req_idx] & (stored_tag == req_tag);
    assign proc_stall = (state_q != S_IDLE) | (proc_read & ~hit);

    assign mem_read = mem_read_q;
    assign mem_addr = mem_addr_q;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        mem_read_d = mem_read_q;
        mem_addr_d = mem_addr_q;
        fill_we    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (inv_all) begin
                    valid_d = '0;
                end
                // A miss seen together with a flush waits one cycle before refilling.
                if (proc_read && !hit && !inv_all) begin
                    state_d    = S_FETCH;
                    mem_read_d = 1'b1;
                    mem_addr_d = {proc_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
                end
            end
            S_FETCH: begin
                if (inv_all) begin
                    valid_d = '0;
                end
                // The in-flight line still lands valid even when a flush coincides.
                if (mem_ready) begin
                    fill_we           = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    state_d           = S_IDLE;
                    mem_read_d        = 1'b0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                mem_read_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
        end
    end

endmodule

// File: tb/tb_icache_direct_mapped.sv
module tb_icache_direct_mapped;

    logic          clk;
    logic          rst_n;
    logic          proc_read;
    logic [31:0]   proc_addr;
    logic [31:0]   proc_rdata;
    logic          proc_stall;
    logic          inv_all;
    logic          mem_read;
    logic [31:0]   mem_addr;
    logic [127:0]  mem_rdata;
    logic          mem_ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    bit ready_hold = 0;

    icache_direct_mapped dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_addr  (proc_addr),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .inv_all    (inv_all),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5EED_1357;
    endfunction

    // Backing memory: always presents the line addressed by mem_addr.
    always_comb begin
        mem_rdata = '0;
        for (int w = 0; w < 4; w++) begin
            mem_rdata[w*32 +: 32] = word_of(mem_addr + 32'(w * 4));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with the cache idle. Holds the fetch until it is
    // served, answering the refill after 'waits' extra S_FETCH cycles.
    task automatic fetch(input logic [31:0] addr, input int waits, input int exp_stall,
                         input int exp_miss, input bit inv_at_ready);
        int  stalls = 0;
        int  fcyc   = 0;
        int  rises  = 0;
        bit  done   = 0;
        logic prev_mr;
        proc_read = 1'b1;
        proc_addr = addr;
        exp_q.push_back(word_of(addr));
        prev_mr = mem_read;
        for (int c = 0; c < 40 && !done; c++) begin
            mem_ready = ready_hold || (mem_read && fcyc == waits);
            inv_all   = inv_at_ready && mem_read && mem_ready;
            if (mem_read && !prev_mr) begin
                rises++;
                chk("mem_addr", mem_addr, addr & ~32'hF);
            end
            prev_mr = mem_read;
            #3;
            if (!proc_stall) begin
                chk("rdata", proc_rdata, exp_q.pop_front());
                done = 1;
            end else begin
                stalls++;
            end
            if (mem_read) fcyc++;
            @(posedge clk);
            #1;
        end
        mem_ready = ready_hold;
        inv_all   = 1'b0;
        chk("served", 32'(done), 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
        chk("mem_read_pulses", 32'(rises), 32'(exp_miss));
    endtask

    initial begin
        rst_n     = 1'b0;
        proc_read = 1'b1;
        proc_addr = 32'h0;
        inv_all   = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_stall_read", 32'(proc_stall), 32'd1);
        proc_read = 1'b0;
        #1;
        chk("rst_stall_idle", 32'(proc_stall), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // cold miss, then hits in the same line
        fetch(32'h00, 3, 5, 1, 0);
        fetch(32'h04, 0, 0, 0, 0);
        fetch(32'h08, 0, 0, 0, 0);
        fetch(32'h0C, 0, 0, 0, 0);

        // conflict on index 0
        fetch(32'h80, 1, 3, 1, 0);
        fetch(32'h84, 0, 0, 0, 0);
        fetch(32'h00, 0, 2, 1, 0);

        // zero-wait memory
        ready_hold = 1;
        fetch(32'h10, 0, 2, 1, 0);
        fetch(32'h14, 0, 0, 0, 0);
        fetch(32'h40, 0, 2, 1, 0);
        ready_hold = 0;
        mem_ready  = 1'b0;

        // flush from idle: same-cycle lookup misses, no refill launched that cycle
        fetch(32'h04, 0, 0, 0, 0);
        proc_read = 1'b1;
        proc_addr = 32'h04;
        inv_all   = 1'b1;
        #3;
        chk("flush_forced_miss", 32'(proc_stall), 32'd1);
        @(posedge clk);
        #1;
        inv_all = 1'b0;
        chk("flush_no_launch", 32'(mem_read), 32'd0);
        fetch(32'h04, 1, 3, 1, 0);
        fetch(32'h10, 0, 2, 1, 0);

        // flush coinciding with mem_ready: only the refilled line survives
        fetch(32'h20, 2, 4, 1, 1);
        fetch(32'h24, 0, 0, 0, 0);
        fetch(32'h10, 0, 2, 1, 0);
        fetch(32'h00, 0, 2, 1, 0);

        // reset in the middle of a refill
        proc_read = 1'b1;
        proc_addr = 32'h30;
        @(posedge clk);
        #1;
        chk("pre_rst_mem_read", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_read", 32'(mem_read), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_stall", 32'(proc_stall), 32'd1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        proc_read = 1'b0;
        mem_ready = 1'b1;
        #3;
        chk("late_ready_stall", 32'(proc_stall), 32'd0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        chk("late_ready_ignored", 32'(mem_read), 32'd0);
        fetch(32'h30, 0, 2, 1, 0);
        fetch(32'h00, 0, 2, 1, 0);
        fetch(32'h34, 0, 0, 0, 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
